crypto_reg_slave: RTL

CRYPTO_REG_SLAVE -- requirements
Module: crypto_reg_slave

---
 rtl/crypto_reg_slave.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/crypto_reg_slave.sv
// Register slave for a crypto accelerator: NUM_REGS R/W words plus one read-only status word.
// Byte-strobe writes are enabled by defining CRYPTO_REG_SLAVE_STRB_EN; otherwise full words are written.
module crypto_reg_slave #(
  parameter int NUM_REGS   = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [ADDR_WIDTH-1:0]    awaddr_i,
  input  logic                     awvalid_i,
  output logic                     awready_o,
  input  logic [31:0]              wdata_i,
  input  logic [3:0]               wstrb_i,
  input  logic                     wvalid_i,
  output logic                     wready_o,
  output logic [1:0]               bresp_o,
  output logic                     bvalid_o,
  input  logic                     bready_i,
  input  logic [ADDR_WIDTH-1:0]    araddr_i,
  input  logic                     arvalid_i,
  output logic                     arready_o,
  output logic [31:0]              rdata_o,
  output logic [1:0]               rresp_o,
  output logic                     rvalid_o,
  input  logic                     rready_i,
  input  logic [31:0]              status_i,
  output logic [NUM_REGS*32-1:0]   reg_o,
  output logic [NUM_REGS-1:0]      reg_wr_o
);
  localparam int IW = ADDR_WIDTH - 2;
  localparam logic [IW-1:0] STATUS_IDX = IW'(NUM_REGS);

  logic [31:0]   r_regs [NUM_REGS];
  logic          r_aw_held, r_w_held;
  logic [IW-1:0] r_aw_idx;
  logic [31:0]   r_wdata;
  logic [31:0]   w_wmask;
  logic          w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_wr_legal;
  logic [IW-1:0] w_ar_idx;
  logic [31:0]   w_rd_data;
  logic [1:0]    w_rd_resp;
  logic          w_unused;

  assign awready_o  = !r_aw_held && !bvalid_o;
  assign wready_o   = !r_w_held && !bvalid_o;
  assign arready_o  = !rvalid_o;
  assign w_aw_hs    = awvalid_i && awready_o;
  assign w_w_hs     = wvalid_i && wready_o;
  assign w_ar_hs    = arvalid_i && arready_o;
  assign w_commit   = r_aw_held && r_w_held;
  assign w_wr_legal = r_aw_idx < STATUS_IDX;
  assign w_ar_idx   = araddr_i[ADDR_WIDTH-1:2];

`ifdef CRYPTO_REG_SLAVE_STRB_EN
  logic [3:0] r_wstrb;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     r_wstrb <= '0;
    else if (w_w_hs) r_wstrb <= wstrb_i;
  end
  assign w_wmask  = {{8{r_wstrb[3]}}, {8{r_wstrb[2]}}, {8{r_wstrb[1]}}, {8{r_wstrb[0]}}};
  assign w_unused = ^{awaddr_i[1:0], araddr_i[1:0]};
`else
  assign w_wmask  = '1;
  assign w_unused = ^{awaddr_i[1:0], araddr_i[1:0], wstrb_i};
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
      reg_wr_o <= '0;
    end else begin
      reg_wr_o <= '0;
      if (w_commit) begin
        for (int k = 0; k < NUM_REGS; k++) begin
          if (r_aw_idx == IW'(k)) begin
            r_regs[k]   <= (r_regs[k] & ~w_wmask) | (r_wdata & w_wmask);
            reg_wr_o[k] <= 1'b1;
          end
        end
      end
    end
  end

  // Read mux samples pre-commit contents, so a same-cycle write is not visible.
  always_comb begin
    w_rd_data = '0;
    w_rd_resp = 2'b10;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (w_ar_idx == IW'(k)) begin
        w_rd_data = r_regs[k];
        w_rd_resp = 2'b00;
      end
    end
    if (w_ar_idx == STATUS_IDX) begin
      w_rd_data = status_i;
      w_rd_resp = 2'b00;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_aw_idx  <= '0;
      r_wdata   <= '0;
      bvalid_o  <= 1'b0;
      bresp_o   <= 2'b00;
      rvalid_o  <= 1'b0;
      rdata_o   <= '0;
      rresp_o   <= 2'b00;
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_aw_idx  <= awaddr_i[ADDR_WIDTH-1:2];
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= wdata_i;
      end
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        bvalid_o  <= 1'b1;
        bresp_o   <= w_wr_legal ? 2'b00 : 2'b10;
      end else if (bvalid_o && bready_i) begin
        bvalid_o <= 1'b0;
      end
      if (w_ar_hs) begin
        rvalid_o <= 1'b1;
        rdata_o  <= w_rd_data;
        rresp_o  <= w_rd_resp;
      end else if (rvalid_o && rready_i) begin
        rvalid_o <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_o
    assign reg_o[32*k +: 32] = r_regs[k];
  end

endmodule
